dpram_port1_rr_arbiter: RTL and testbench
=========================================

Name: dpram_port1_rr_arbiter

Overview:
- Round-robin arbiter that shares the read/write port (port 1) of the 64x16 dual-port RAM with enable on each port among NREQ requesters.
- Each requester issues single-word read or write transactions over a valid/ready handshake.
- Each accepted transaction produces exactly one response, tagged with the requester ID, one cycle later.
- Port 2 of the RAM is not touched by this block. It stays a direct read port for a separate consumer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 6, RAM address width.
- DW, 16, RAM data width.
- IDW, 2, requester ID width; must equal clog2(NREQ).

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_we  input  NREQ  per-requester write (1) / read (0).
- req_addr  input  NREQ*AW  flattened addresses; requester i occupies bits [i*AW +: AW].
- req_wdata  input  NREQ*DW  flattened write data; requester i occupies bits [i*DW +: DW].
- req_ready  output  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i] at the clock edge.
- rsp_valid  output  1  response valid.
- rsp_id  output  IDW  requester index of the response.
- rsp_we  output  1  1 = write acknowledge, 0 = read data.
- rsp_rdata  output  DW  RAM word at the accepted address.
- ram_en1  output  1  drives RAM en1.
- ram_we  output  1  drives RAM we.
- ram_addr1  output  AW  drives RAM addr1.
- ram_di  output  DW  drives RAM DI.
- ram_do1  input  DW  from RAM DO1.

Behaviour:
- State: rotating priority pointer ptr (IDW bits), rsp_valid, rsp_id, rsp_we.
- Reset (async, RST_N low): ptr=0, rsp_valid=0, rsp_id=0, rsp_we=0. While RST_N is low, req_ready=0 and ram_en1=0 (combinationally gated).
- Arbitration is combinational each cycle. The grant g is the first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NREQ.
- req_ready[g]=1 and all other bits are 0. With no valid request, req_ready=0.
- RAM drive:
  - ram_en1 = |req_valid (when not in reset).
  - ram_we = req_we[g] & ram_en1.
  - ram_addr1 and ram_di are muxed from requester g.
  - When idle, ram_we=0, and ram_addr1/ram_di are don't-care but held at the requester-0 values.
- Every cycle with ram_en1=1 is a transfer for requester g. On that edge:
  - ptr <= (g+1) mod NREQ.
  - rsp_valid <= 1, rsp_id <= g, rsp_we <= req_we[g].
- Idle cycle: rsp_valid <= 0, ptr unchanged.
- Latency: response appears exactly 1 cycle after the accepting edge.
- Throughput: one transaction per cycle, back-to-back.
- rsp_rdata = ram_do1, passed through combinationally; meaningful only when rsp_valid=1.
  - Read response: the word stored at the address at the accepting edge.
  - Write response: the newly written data (write-first, because the RAM registers the read address on the write edge).
- Fairness: a requester holding valid is granted within NREQ-1 cycles. Requesters not granted must hold valid and payload stable until granted; the block does not buffer.
- A requester may deassert valid before being granted. This is not an error, and the pointer is unaffected.
- Simultaneous response and new grant is the normal pipelined case; no stall exists, because the response path has no backpressure.
- Reset mid-operation: any response due next cycle is dropped (rsp_valid forced 0) and ptr returns to 0. RAM contents are not cleared.
- Out-of-range addresses cannot occur (AW matches RAM depth).

Decomposition:
- Package dpram_arb_pkg holds the defaults for AW/DW/NREQ and the response-type encoding constants RSP_READ=0 and RSP_WRITE=1.
- Sub-module rr_pick: combinational rotating-priority one-hot picker with inputs (valid vector, ptr) and outputs (one-hot grant, index, any). It is instantiated once.
- The top module holds ptr, the response registers and the muxes.

Test Plan:
- Reset then idle: RST_N low for 3 cycles, then high with all valid=0.
  -> req_ready=0, ram_en1=0, rsp_valid=0, and ptr stays 0 for 10 cycles.
- Single write then read: requester 2 writes addr 0x05 data 0xBEEF, then reads addr 0x05.
  -> First cycle after the write edge: rsp_valid=1, id=2, we=1, rdata=0xBEEF.
  -> Next cycle: rsp_valid=1, id=2, we=0, rdata=0xBEEF.
- Round robin under full load: all 4 requesters hold valid continuously for 8 cycles.
  -> Grants are 0,1,2,3,0,1,2,3 and rsp_id follows one cycle later.
- Pointer skip: ptr=1, only requesters 0 and 3 valid.
  -> Grant 3, then 0, then 3.
  -> Requester 3 reads addr 0x3F and gets the value written earlier at 0x3F (wrap address).
- Back-to-back mixed: requester 1 writes 0x10=0x1234 while requester 0 is pending.
  -> Requester 0 is granted next, reads 0x10 and gets rdata=0x1234 with id=0.
- Reset mid-transfer: assert RST_N low in the same cycle as a grant edge.
  -> rsp_valid=0 immediately, ptr=0, req_ready=0 while reset is held.

Source files
------------

// File: rtl/dpram_arb_pkg.sv
// ----------------------------------------------------------------------------
// dpram_arb_pkg
// Shared defaults and encodings for the port-1 round-robin arbiter of the
// 64x16 dual-port RAM.
//   NREQ_DEF  : default number of requesters
//   AW_DEF    : default RAM address width (64 words)
//   DW_DEF    : default RAM data width
//   RSP_READ  : rsp_we value for a read-data response
//   RSP_WRITE : rsp_we value for a write acknowledge
// ----------------------------------------------------------------------------
package dpram_arb_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned AW_DEF   = 6;
    localparam int unsigned DW_DEF   = 16;

    localparam logic RSP_READ  = 1'b0;
    localparam logic RSP_WRITE = 1'b1;

endpackage

// File: rtl/dpram_port1_rr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker. Returns the first set bit of
// valid_i, searching from index ptr_i upwards and wrapping modulo NREQ.
//   valid_i : per-requester valid vector
//   ptr_i   : index holding highest priority this cycle (always < NREQ)
//   grant_o : one-hot grant, all-zero when nothing is valid
//   idx_o   : index of the granted requester, 0 when nothing is valid
//   any_o   : at least one requester is valid
// ----------------------------------------------------------------------------
module rr_pick
    import dpram_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    logic           found;
    logic [IDW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            cand = IDW'((int'(ptr_i) + k) % int'(NREQ));
            if (!found && valid_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

    assign any_o = |valid_i;

endmodule

// File: rtl/dpram_port1_rr_arbiter.sv
// ----------------------------------------------------------------------------
// dpram_port1_rr_arbiter
// Shares port 1 (read/write) of the 64x16 dual-port RAM among NREQ
// requesters with a rotating-priority arbiter. One single-word transaction
// per cycle; every accepted transaction yields one response one cycle later,
// tagged with the requester index. Port 2 of the RAM is not driven here.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   req_valid/we        : per-requester valid and write(1)/read(0)
//   req_addr/wdata      : flattened per-requester address and write data
//   req_ready           : one-hot grant (gated low during reset)
//   rsp_valid/id/we     : response valid, requester index, write-ack flag
//   rsp_rdata           : RAM DO1 passed through
//   ram_en1/we/addr1/di : RAM port-1 drive
//   ram_do1             : RAM port-1 read data
// ----------------------------------------------------------------------------
module dpram_port1_rr_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic               rsp_we,
    output logic [DW-1:0]      rsp_rdata,
    output logic               ram_en1,
    output logic               ram_we,
    output logic [AW-1:0]      ram_addr1,
    output logic [DW-1:0]      ram_di,
    input  logic [DW-1:0]      ram_do1
);

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic            rsp_we_q, rsp_we_d;

    logic [NREQ-1:0] pick_grant;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Grants and RAM enable are masked while reset is held so nothing reaches
    // the RAM even if requesters are already asserting valid.
    assign req_ready = pick_grant & {NREQ{RST_N}};
    assign ram_en1   = pick_any & RST_N;

    // pick_idx is 0 when idle, so the payload mux then follows requester 0.
    assign ram_we    = req_we[pick_idx] & ram_en1;
    assign ram_addr1 = req_addr[int'(pick_idx)*int'(AW) +: AW];
    assign ram_di    = req_wdata[int'(pick_idx)*int'(DW) +: DW];

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = ram_en1;
        rsp_id_d    = rsp_id_q;
        rsp_we_d    = rsp_we_q;
        if (ram_en1) begin
            ptr_d    = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
            rsp_id_d = pick_idx;
            rsp_we_d = req_we[pick_idx] ? RSP_WRITE : RSP_READ;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_we_q    <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_we_q    <= rsp_we_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = ram_do1;

endmodule

// File: tb/tb_dpram_port1_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dpram_port1_rr_arbiter
// Directed bench for dpram_port1_rr_arbiter with a behavioural 64x16 RAM
// port 1 (write-first, registered read) attached to the RAM-side ports.
// ----------------------------------------------------------------------------
module tb_dpram_port1_rr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 6;
    localparam int DW   = 16;
    localparam int IDW  = 2;

    logic               CLK = 1'b0;
    logic               RST_N;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_we;
    logic [DW-1:0]      rsp_rdata;
    logic               ram_en1;
    logic               ram_we;
    logic [AW-1:0]      ram_addr1;
    logic [DW-1:0]      ram_di;
    logic [DW-1:0]      ram_do1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    dpram_port1_rr_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW),
        .IDW  (IDW)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_we    (rsp_we),
        .rsp_rdata (rsp_rdata),
        .ram_en1   (ram_en1),
        .ram_we    (ram_we),
        .ram_addr1 (ram_addr1),
        .ram_di    (ram_di),
        .ram_do1   (ram_do1)
    );

    // RAM port 1 model: write-first, output registered on the enabled edge.
    logic [DW-1:0] mem [64];
    logic [DW-1:0] do1_q;

    always @(posedge CLK) begin
        if (ram_en1) begin
            if (ram_we) begin
                mem[ram_addr1] <= ram_di;
                do1_q          <= ram_di;
            end else begin
                do1_q <= mem[ram_addr1];
            end
        end
    end
    assign ram_do1 = do1_q;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_we    = '0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        req_valid = 4'hF;
        #1;
        n_tests++;
        if (req_ready !== 4'b0000 || ram_en1 !== 1'b0 || rsp_valid !== 1'b0) begin
            $display("FAIL reset_gate: ready=%b en1=%b rsp_valid=%b, want 0000/0/0",
                     req_ready, ram_en1, rsp_valid);
            n_fail++;
        end
        clear_reqs();
        repeat (3) tick();
        RST_N = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_tests++;
            if (req_ready !== 4'b0000 || ram_en1 !== 1'b0 || rsp_valid !== 1'b0) begin
                $display("FAIL idle_%0d: ready=%b en1=%b rsp_valid=%b, want 0000/0/0",
                         k, req_ready, ram_en1, rsp_valid);
                n_fail++;
            end
        end
        // Idle payload follows requester 0 with the write strobe low.
        req_addr[0 +: AW] = 6'h2A;
        req_we[0] = 1'b1;
        #1;
        n_tests++;
        if (ram_addr1 !== 6'h2A || ram_we !== 1'b0) begin
            $display("FAIL idle_mux: addr1=%h we=%b, want 2a/0", ram_addr1, ram_we);
            n_fail++;
        end
        // ptr still 0: all valid grants requester 0. Withdrawn before the edge.
        req_valid = 4'hF;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL reset_ptr: ready=%b, want 0001", req_ready);
            n_fail++;
        end
        clear_reqs();
        tick();
    endtask

    task automatic test_write_read();
        set_req(2, 1'b1, 6'h05, 16'hBEEF);
        #1;
        n_tests++;
        if (req_ready !== 4'b0100 || ram_en1 !== 1'b1 || ram_we !== 1'b1 ||
            ram_addr1 !== 6'h05 || ram_di !== 16'hBEEF) begin
            $display("FAIL wr_drive: ready=%b en1=%b we=%b addr=%h di=%h, want 0100/1/1/05/beef",
                     req_ready, ram_en1, ram_we, ram_addr1, ram_di);
            n_fail++;
        end
        tick();
        set_req(2, 1'b0, 6'h05, 16'h0000);
        #1;
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_we !== 1'b1 ||
            rsp_rdata !== 16'hBEEF) begin
            $display("FAIL wr_rsp: v=%b id=%0d we=%b rdata=%h, want 1/2/1/beef",
                     rsp_valid, rsp_id, rsp_we, rsp_rdata);
            n_fail++;
        end
        n_tests++;
        if (req_ready !== 4'b0100 || ram_we !== 1'b0) begin
            $display("FAIL rd_drive: ready=%b we=%b, want 0100/0", req_ready, ram_we);
            n_fail++;
        end
        tick();
        clear_reqs();
        #1;
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_we !== 1'b0 ||
            rsp_rdata !== 16'hBEEF) begin
            $display("FAIL rd_rsp: v=%b id=%0d we=%b rdata=%h, want 1/2/0/beef",
                     rsp_valid, rsp_id, rsp_we, rsp_rdata);
            n_fail++;
        end
        tick();
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            $display("FAIL rsp_idle: v=%b, want 0", rsp_valid);
            n_fail++;
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_g;
        logic [IDW-1:0]  exp_id;
        // ptr is 3: requester 3 seeds 0x3F and moves ptr to 0.
        set_req(3, 1'b1, 6'h3F, 16'hA5C3);
        tick();
        clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 6'h00, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_g = 4'b0001 << (k % 4);
            n_tests++;
            if (req_ready !== exp_g) begin
                $display("FAIL rr_grant_%0d: ready=%b, want %b", k, req_ready, exp_g);
                n_fail++;
            end
            if (k > 0) begin
                exp_id = 2'((k - 1) % 4);
                n_tests++;
                if (rsp_valid !== 1'b1 || rsp_id !== exp_id) begin
                    $display("FAIL rr_rsp_%0d: v=%b id=%0d, want 1/%0d",
                             k, rsp_valid, rsp_id, exp_id);
                    n_fail++;
                end
            end
            tick();
        end
        clear_reqs();
        #1;
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin
            $display("FAIL rr_rsp_last: v=%b id=%0d, want 1/3", rsp_valid, rsp_id);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_pointer_skip();
        // Requester 0 alone moves ptr from 0 to 1.
        set_req(0, 1'b0, 6'h05, 16'h0000);
        tick();
        set_req(3, 1'b0, 6'h3F, 16'h0000);
        #1;
        n_tests++;
        if (req_ready !== 4'b1000) begin
            $display("FAIL skip_g0: ready=%b, want 1000", req_ready);
            n_fail++;
        end
        tick();
        n_tests++;
        if (req_ready !== 4'b0001 || rsp_id !== 2'd3 || rsp_rdata !== 16'hA5C3) begin
            $display("FAIL skip_g1: ready=%b id=%0d rdata=%h, want 0001/3/a5c3",
                     req_ready, rsp_id, rsp_rdata);
            n_fail++;
        end
        tick();
        n_tests++;
        if (req_ready !== 4'b1000 || rsp_id !== 2'd0 || rsp_rdata !== 16'hBEEF) begin
            $display("FAIL skip_g2: ready=%b id=%0d rdata=%h, want 1000/0/beef",
                     req_ready, rsp_id, rsp_rdata);
            n_fail++;
        end
        tick();
        clear_reqs();
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_rdata !== 16'hA5C3) begin
            $display("FAIL skip_rsp3: v=%b id=%0d rdata=%h, want 1/3/a5c3",
                     rsp_valid, rsp_id, rsp_rdata);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        // ptr is 0; requester 0 alone moves it to 1.
        set_req(0, 1'b0, 6'h00, 16'h0000);
        tick();
        set_req(1, 1'b1, 6'h10, 16'h1234);
        set_req(0, 1'b0, 6'h10, 16'h0000);
        #1;
        n_tests++;
        if (req_ready !== 4'b0010) begin
            $display("FAIL b2b_g0: ready=%b, want 0010", req_ready);
            n_fail++;
        end
        tick();
        req_valid[1] = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001 || rsp_id !== 2'd1 || rsp_we !== 1'b1 ||
            rsp_rdata !== 16'h1234) begin
            $display("FAIL b2b_wr: ready=%b id=%0d we=%b rdata=%h, want 0001/1/1/1234",
                     req_ready, rsp_id, rsp_we, rsp_rdata);
            n_fail++;
        end
        tick();
        clear_reqs();
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_we !== 1'b0 ||
            rsp_rdata !== 16'h1234) begin
            $display("FAIL b2b_rd: v=%b id=%0d we=%b rdata=%h, want 1/0/0/1234",
                     rsp_valid, rsp_id, rsp_we, rsp_rdata);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_reset_mid();
        // ptr is 1; granting requester 2 would move it to 3.
        set_req(2, 1'b0, 6'h05, 16'h0000);
        tick();
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
            $display("FAIL mid_pre: v=%b id=%0d, want 1/2", rsp_valid, rsp_id);
            n_fail++;
        end
        RST_N = 1'b0;
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || ram_en1 !== 1'b0) begin
            $display("FAIL mid_rst: v=%b ready=%b en1=%b, want 0/0000/0",
                     rsp_valid, req_ready, ram_en1);
            n_fail++;
        end
        tick();
        tick();
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            $display("FAIL mid_hold: v=%b ready=%b, want 0/0000", rsp_valid, req_ready);
            n_fail++;
        end
        clear_reqs();
        RST_N = 1'b1;
        req_valid = 4'hF;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL mid_ptr: ready=%b, want 0001", req_ready);
            n_fail++;
        end
        clear_reqs();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        do1_q     = '0;
        RST_N     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        tick();
        test_reset();
        test_write_read();
        test_round_robin();
        test_pointer_skip();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
